// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: fetch/decode/exec/mem/writeback sequencing with sticky fault flags.
// Optional feature: define SHIFT_OPS_EN to decode sll/srl (funct 0x00/0x02); otherwise they fault.
module multicycle_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_wr_en,
    output logic               ir_wr_en,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic               reg_wr_en,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src1,
    output logic               alu_src2,
    output logic               branch_eq,
    output logic               branch_neq,
    output logic               jump,
    output logic               jump_reg,
    output logic               link,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               invalid_inst,
    output logic               mem_timeout,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_NOR = 4'd6;
`ifdef SHIFT_OPS_EN
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
`endif
    localparam logic [3:0] ALU_SGT = 4'd9;

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           fsm;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;

    logic       is_rtype, is_shift, is_imm, is_lw, is_sw;
    logic       is_beq, is_bne, is_j, is_jal, is_jr, is_valid;
    logic [3:0] exec_alu;

    assign state = fsm;

    // Instruction classification from the fields captured on DECODE entry.
    always_comb begin
        is_rtype = 1'b0;
        is_shift = 1'b0;
        is_imm   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        exec_alu = 4'hF;
        case (op_q)
            6'h00: begin
                case (fn_q)
                    6'h20: begin is_rtype = 1'b1; exec_alu = ALU_ADD; end
                    6'h22: begin is_rtype = 1'b1; exec_alu = ALU_SUB; end
                    6'h24: begin is_rtype = 1'b1; exec_alu = ALU_AND; end
                    6'h25: begin is_rtype = 1'b1; exec_alu = ALU_OR;  end
                    6'h26: begin is_rtype = 1'b1; exec_alu = ALU_XOR; end
                    6'h27: begin is_rtype = 1'b1; exec_alu = ALU_NOR; end
                    6'h2A: begin is_rtype = 1'b1; exec_alu = ALU_SLT; end
                    6'h29: begin is_rtype = 1'b1; exec_alu = ALU_SGT; end
                    6'h08: is_jr = 1'b1;
`ifdef SHIFT_OPS_EN
                    6'h00: begin is_rtype = 1'b1; is_shift = 1'b1; exec_alu = ALU_SLL; end
                    6'h02: begin is_rtype = 1'b1; is_shift = 1'b1; exec_alu = ALU_SRL; end
`endif
                    default: ;
                endcase
            end
            6'h08: begin is_imm = 1'b1; exec_alu = ALU_ADD; end
            6'h0C: begin is_imm = 1'b1; exec_alu = ALU_AND; end
            6'h0D: begin is_imm = 1'b1; exec_alu = ALU_OR;  end
            6'h0E: begin is_imm = 1'b1; exec_alu = ALU_XOR; end
            6'h0A: begin is_imm = 1'b1; exec_alu = ALU_SLT; end
            6'h23: begin is_lw  = 1'b1; exec_alu = ALU_ADD; end
            6'h2B: begin is_sw  = 1'b1; exec_alu = ALU_ADD; end
            6'h04: begin is_beq = 1'b1; exec_alu = ALU_SUB; end
            6'h05: begin is_bne = 1'b1; exec_alu = ALU_SUB; end
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            default: ;
        endcase
        is_valid = is_rtype | is_imm | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_jr;
    end

    // Wait handling is shared by FETCH and MEM: ready on the terminal count still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= FETCH;
            wait_cnt     <= '0;
            op_q         <= '0;
            fn_q         <= '0;
            invalid_inst <= 1'b0;
            mem_timeout  <= 1'b0;
        end else begin
            case (fsm)
                FETCH: begin
                    if (mem_ready) begin
                        fsm      <= DECODE;
                        wait_cnt <= '0;
                        op_q     <= opcode;
                        fn_q     <= funct;
                    end else if (wait_cnt == CNT_MAX) begin
                        fsm         <= ERROR;
                        wait_cnt    <= '0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    if (!is_valid) begin
                        fsm          <= ERROR;
                        invalid_inst <= 1'b1;
                    end else if (is_j || is_jal || is_jr) begin
                        fsm <= FETCH;
                    end else begin
                        fsm <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_lw || is_sw)        fsm <= MEM;
                    else if (is_beq || is_bne) fsm <= FETCH;
                    else                       fsm <= WB;
                end
                MEM: begin
                    if (mem_ready) begin
                        fsm      <= is_lw ? WB : FETCH;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_MAX) begin
                        fsm         <= ERROR;
                        wait_cnt    <= '0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WB:      fsm <= FETCH;
                ERROR:   fsm <= ERROR;
                default: fsm <= FETCH;
            endcase
        end
    end

    // Moore decode; FETCH strobes also qualify on mem_ready. Reset masks all but mem_rd_en.
    always_comb begin
        pc_wr_en   = 1'b0;
        ir_wr_en   = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        reg_wr_en  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src1   = 1'b0;
        alu_src2   = 1'b0;
        branch_eq  = 1'b0;
        branch_neq = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        link       = 1'b0;
        alu_op     = '1;
        case (fsm)
            FETCH: begin
                mem_rd_en = 1'b1;
                ir_wr_en  = mem_ready;
                pc_wr_en  = mem_ready;
            end
            DECODE: begin
                pc_wr_en  = is_j | is_jal | is_jr;
                jump      = is_j | is_jal;
                jump_reg  = is_jr;
                reg_wr_en = is_jal;
                link      = is_jal;
            end
            EXEC: begin
                alu_op     = ALUOP_W'(exec_alu);
                alu_src1   = is_shift;
                alu_src2   = is_imm | is_lw | is_sw;
                pc_wr_en   = is_beq | is_bne;
                branch_eq  = is_beq;
                branch_neq = is_bne;
            end
            MEM: begin
                mem_rd_en = is_lw;
                mem_wr_en = is_sw;
            end
            WB: begin
                reg_wr_en  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
            end
            default: ;
        endcase
        if (rst) begin
            pc_wr_en   = 1'b0;
            ir_wr_en   = 1'b0;
            mem_wr_en  = 1'b0;
            reg_wr_en  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src1   = 1'b0;
            alu_src2   = 1'b0;
            branch_eq  = 1'b0;
            branch_neq = 1'b0;
            jump       = 1'b0;
            jump_reg   = 1'b0;
            link       = 1'b0;
            alu_op     = '1;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 4, SHALL set the alu_op width; values >= 4 are legal.
REQ-002 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum number of consecutive cycles spent waiting on mem_ready.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 opcode, funct  in  6 each  instruction fields from the external instruction register.
REQ-006 mem_ready  in  1  memory completion for the current read or write.
REQ-007 pc_wr_en, ir_wr_en  out  1 each  PC and instruction-register write strobes.
REQ-008 mem_rd_en, mem_wr_en, reg_wr_en  out  1 each  memory and register-file enables.
REQ-009 reg_dst, mem_to_reg, alu_src1, alu_src2  out  1 each  datapath mux selects (alu_src1=1 selects shamt; alu_src2=1 selects immediate).
REQ-010 branch_eq, branch_neq, jump, jump_reg, link  out  1 each  PC-source qualifiers; link=1 writes PC+4 to $31.
REQ-011 alu_op  out  ALUOP_W  ALU operation code, zero-extended: add 0, sub 1, and 2, or 3, slt 4, xor 5, nor 6, sll 7, srl 8, sgt 9, none all-ones.
REQ-012 invalid_inst  out  1  sticky fault flag.
REQ-013 mem_timeout  out  1  sticky flag for a memory wait that exceeded MEM_TIMEOUT.
REQ-014 state  out  3  current FSM state, for debug.

Function
REQ-015 FSM states SHALL be encoded as FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5.
REQ-016 Outputs SHALL be Moore-decoded from the state and from opcode/funct captured on DECODE entry; every strobe not listed for a state SHALL be 0, and alu_op SHALL be all-ones.
REQ-017 FETCH SHALL assert mem_rd_en; when mem_ready=1 it SHALL pulse ir_wr_en and pc_wr_en for that cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-018 DECODE SHALL last exactly one cycle and transition as follows.
  - j: pulse pc_wr_en with jump, go to FETCH.
  - jal: same as j, plus reg_wr_en and link.
  - jr (opcode 0x00, funct 0x08): pulse pc_wr_en with jump_reg, go to FETCH.
  - undecodable opcode or funct: go to ERROR.
  - all other instructions: go to EXEC.
REQ-019 Decodable set: R-type funct 0x20/22/24/25/26/27/2A/29 (and 0x00/0x02 per REQ-033); opcodes 0x08 addi, 0x0C andi, 0x0D ori, 0x0E xori, 0x0A slti, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j, 0x03 jal.
REQ-020 EXEC SHALL drive alu_op and the ALU source selects.
  - R-type and immediate instructions: go to WB.
  - lw/sw: alu_op=add, alu_src2=1, go to MEM.
  - beq/bne: alu_op=sub, pulse pc_wr_en with branch_eq or branch_neq, go to FETCH.
REQ-021 MEM SHALL hold mem_rd_en (lw) or mem_wr_en (sw) until mem_ready=1, then go to WB for lw or to FETCH for sw.
REQ-022 WB SHALL pulse reg_wr_en for one cycle, with reg_dst=1 for R-type and mem_to_reg=1 for lw, then go to FETCH.
REQ-023 Latencies in cycles, with zero-wait memory: R/imm 4, lw 5, sw 4, branch 3, jump 2; each cycle of mem_ready=0 adds one cycle.
REQ-024 A wait counter of width ceil(log2(MEM_TIMEOUT+1)) SHALL clear on every state change.
  - It SHALL increment on each FETCH or MEM cycle with mem_ready=0.
  - Reaching MEM_TIMEOUT SHALL set mem_timeout and move the FSM to ERROR on the next edge.
REQ-025 mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT SHALL count as completion, with no timeout.
REQ-026 ERROR SHALL hold every strobe at 0 and keep invalid_inst or mem_timeout asserted until rst.
REQ-027 In DECODE, invalid_inst SHALL be set on the edge entering ERROR.

Reset
REQ-028 rst=1 SHALL force the following on the next clk edge, overriding all other transitions including a mid-access MEM state:
  - state=FETCH;
  - wait counter, invalid_inst and mem_timeout cleared;
  - captured opcode/funct cleared.
REQ-029 During the first cycle after rst deasserts, the block SHALL be in FETCH with mem_rd_en=1.
REQ-030 No strobe other than mem_rd_en SHALL be asserted while rst=1.

Configuration
REQ-031 Macro SHIFT_OPS_EN SHALL control decoding of shift instructions.
REQ-032 With SHIFT_OPS_EN undefined, funct 0x00/0x02 SHALL be undecodable and lead to ERROR.
REQ-033 With SHIFT_OPS_EN defined, sll (funct 0x00) and srl (funct 0x02) SHALL be decoded with alu_src1=1 in EXEC and alu_op 7 and 8 respectively.

Verification
REQ-034 Reset then add (op 0, funct 0x20), mem_ready=1 always -> states 0,1,2,4,0; alu_op=0 in EXEC; reg_wr_en=1 and reg_dst=1 only in WB.
REQ-035 lw (op 0x23) with mem_ready low for 3 MEM cycles -> 8-cycle instruction; mem_to_reg=1 and reg_wr_en=1 in WB.
REQ-036 beq (op 0x04) -> EXEC alu_op=1, branch_eq=1, pc_wr_en=1; next state 0.
REQ-037 mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> mem_timeout=1 and state=5 after 16 cycles; rst clears both.
REQ-038 op 0, funct 0x00 -> ERROR with invalid_inst=1 without SHIFT_OPS_EN; alu_op=7 and alu_src1=1 in EXEC with it.
REQ-039 jal (op 0x03) -> DECODE asserts jump, link, reg_wr_en and pc_wr_en; next state 0.
